alu_arbiter: RTL and testbench

//  Shares one 32-bit `alu` instance between two requesters (port 0, port 1) using

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu.sv | 24 ++
 rtl/rr_arbiter_2.sv | 16 +
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// State encoding, ALUControl codes and the captured request payload.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } req_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU driven by a 3-bit ALUControl code.
// Unassigned codes (100, 110, 111) produce zero.
import alu_arb_pkg::*;

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_2.sv
// Combinational 2-way round-robin pick; the pointer names the favoured port on a tie.
// A lone valid request always wins regardless of the pointer.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters; one op in flight.
// `ALU_ARB_STATS_EN enables per-port accept counters (otherwise they read 0).
import alu_arb_pkg::*;

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_port,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
);

  state_t      state, state_nxt;
  logic        ptr;
  logic [1:0]  req_valid;
  logic [1:0]  grant;
  logic        accept;
  req_t        req0_pkt, req1_pkt;
  req_t        opnd;
  logic        opnd_port;
  logic [31:0] alu_y;

  assign req_valid = {req1_valid, req0_valid};
  assign req0_pkt  = '{a: req0_a, b: req0_b, op: req0_op};
  assign req1_pkt  = '{a: req1_a, b: req1_b, op: req1_op};

  rr_arbiter_2 u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  alu u_alu (
    .a           (opnd.a),
    .b           (opnd.b),
    .alu_control (opnd.op),
    .result      (alu_y)
  );

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (|grant) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      opnd       <= '0;
      opnd_port  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_port   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opnd      <= grant[1] ? req1_pkt : req0_pkt;
        opnd_port <= grant[1];
        ptr       <= ~grant[1];
      end
      // HOLD is always entered with rsp_valid set, so HOLD+rsp_ready is the handshake.
      if (state == EXEC) begin
        rsp_result <= alu_y;
        rsp_port   <= opnd_port;
        rsp_valid  <= 1'b1;
      end else if (state == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0, cnt1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept) begin
      if (grant[0]) cnt0 <= cnt0 + CNT_W'(1);
      if (grant[1]) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

  assign grant0_cnt = cnt0;
  assign grant1_cnt = cnt1;
`else
  assign grant0_cnt = '0;
  assign grant1_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference.
module tb_alu_arbiter;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]   req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_port;
  logic [31:0]   rsp_result;
  logic [CW-1:0] grant0_cnt, grant1_cnt;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_port(rsp_port),
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Requester-side payloads, held until the model says they were taken.
  logic        p_v[2];
  logic [31:0] p_a[2], p_b[2];
  logic [2:0]  p_op[2];

  // Reference: one transaction outstanding from accept until the response handshake.
  bit          m_out;
  int          m_age;
  int          m_last;
  int          m_gnt;
  int          m_cnt0, m_cnt1;
  logic [31:0] q_res[$];
  bit          q_port[$];
  logic [31:0] obs_res[$];
  bit          obs_port[$];

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'd0;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_req(input int k);
    p_v[k]  = 1'b1;
    p_a[k]  = rand_word();
    p_b[k]  = rand_word();
    p_op[k] = 3'($urandom_range(0, 7));
  endtask

  task automatic model_reset();
    m_out = 0; m_age = 0; m_last = 1; m_gnt = -1;
    m_cnt0 = 0; m_cnt1 = 0;
    q_res.delete(); q_port.delete();
  endtask

  // One clock cycle: drive, check outputs against the reference, advance both.
  task automatic step();
    int g;
    bit exp_v, hs;
    req0_valid = p_v[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_op = p_op[0];
    req1_valid = p_v[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_op = p_op[1];
    #1;
    g = -1;
    if (!m_out) begin
      if (p_v[0] && p_v[1]) g = (m_last == 0) ? 1 : 0;
      else if (p_v[0])      g = 0;
      else if (p_v[1])      g = 1;
    end
    exp_v = m_out && (m_age >= 2);
    check_val("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    check_val("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    check_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
    if (exp_v && q_res.size() > 0) begin
      check_val("rsp_result", rsp_result, q_res[0]);
      check_val("rsp_port", {31'd0, rsp_port}, {31'd0, q_port[0]});
    end
`ifdef ALU_ARB_STATS_EN
    check_val("grant0_cnt", {30'd0, grant0_cnt}, 32'(m_cnt0 % 4));
    check_val("grant1_cnt", {30'd0, grant1_cnt}, 32'(m_cnt1 % 4));
`else
    check_val("grant0_cnt", {30'd0, grant0_cnt}, 32'd0);
    check_val("grant1_cnt", {30'd0, grant1_cnt}, 32'd0);
`endif
    hs = exp_v && rsp_ready;
    if (hs) begin
      obs_res.push_back(rsp_result);
      obs_port.push_back(rsp_port);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (hs) begin
        void'(q_res.pop_front());
        void'(q_port.pop_front());
        m_out = 0;
      end else if (m_out) begin
        m_age++;
      end
      if (g >= 0) begin
        q_res.push_back(ref_alu(p_a[g], p_b[g], p_op[g]));
        q_port.push_back(g[0]);
        m_out = 1; m_age = 1; m_last = g;
        if (g == 0) m_cnt0++; else m_cnt1++;
      end
      m_gnt = g;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_val("rst_result", rsp_result, 32'd0);
    check_val("rst_port", {31'd0, rsp_port}, 32'd0);
    obs_res.delete(); obs_port.delete();
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p_v[k] = 1'b0; p_a[k] = '0; p_b[k] = '0; p_op[k] = '0;
    end
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Port 0 alone: 5 + 7 with the response one EXEC cycle after the accept.
    do_reset();
    p_v[0] = 1; p_a[0] = 5; p_b[0] = 7; p_op[0] = 3'b000;
    step();
    if (m_gnt == 0) p_v[0] = 0;
    step();
    check_val("t1_no_rsp_yet", 32'(obs_res.size()), 32'd0);
    step();
    check_val("t1_rsp_count", 32'(obs_res.size()), 32'd1);
    if (obs_res.size() > 0) begin
      check_val("t1_result", obs_res[0], 32'd12);
      check_val("t1_port", {31'd0, obs_port[0]}, 32'd0);
    end

    // Both valid from reset: port 0 wins first, then port 1.
    do_reset();
    p_v[0] = 1; p_a[0] = 5;            p_b[0] = 7;            p_op[0] = 3'b001;
    p_v[1] = 1; p_a[1] = 32'hF0F0_F0F0; p_b[1] = 32'h0FF0_0FF0; p_op[1] = 3'b010;
    for (int i = 0; i < 12 && obs_res.size() < 2; i++) begin
      step();
      if (m_gnt >= 0) p_v[m_gnt] = 0;
    end
    check_val("t2_rsp_count", 32'(obs_res.size()), 32'd2);
    if (obs_res.size() >= 2) begin
      check_val("t2_port0", {31'd0, obs_port[0]}, 32'd0);
      check_val("t2_res0", obs_res[0], 32'hFFFF_FFFE);
      check_val("t2_port1", {31'd0, obs_port[1]}, 32'd1);
      check_val("t2_res1", obs_res[1], 32'h00F0_00F0);
    end

    // Continuous contention: grants must alternate starting with port 0.
    do_reset();
    new_req(0); new_req(1);
    for (int i = 0; i < 100 && obs_res.size() < 10; i++) begin
      step();
      if (m_gnt >= 0) new_req(m_gnt);
    end
    check_val("t3_rsp_count", 32'(obs_res.size()), 32'd10);
    foreach (obs_port[i]) check_val("t3_alternate", {31'd0, obs_port[i]}, 32'(i % 2));

    // Backpressure: response held 5 cycles, no grants; release returns to IDLE.
    do_reset();
    new_req(0);
    step();
    if (m_gnt == 0) p_v[0] = 0;
    new_req(1);
    rsp_ready = 0;
    step();
    for (int i = 0; i < 5; i++) step();
    rsp_ready = 1;
    step();
    step();
    check_val("t4_p1_granted", 32'(m_gnt), 32'd1);
    if (m_gnt == 1) p_v[1] = 0;
    for (int i = 0; i < 3; i++) step();
    check_val("t4_rsp_count", 32'(obs_res.size()), 32'd2);

    // Reset while the op is executing: it must never be reported.
    do_reset();
    new_req(0);
    step();
    if (m_gnt == 0) p_v[0] = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) step();
    check_val("t5_dropped", 32'(obs_res.size()), 32'd0);
    new_req(0); new_req(1);
    step();
    check_val("t5_ptr_port0", 32'(m_gnt), 32'd0);

    // Port-1-only stream for the accept counters.
    do_reset();
    for (int i = 0; i < 40 && m_cnt1 < 5; i++) begin
      if (!p_v[1] && m_cnt1 < 5) new_req(1);
      step();
      if (m_gnt == 1) p_v[1] = 0;
    end
    step();
`ifdef ALU_ARB_STATS_EN
    check_val("t6_cnt1_wrap", {30'd0, grant1_cnt}, 32'd1);
`else
    check_val("t6_cnt1_off", {30'd0, grant1_cnt}, 32'd0);
`endif
    check_val("t6_cnt0", {30'd0, grant0_cnt}, 32'd0);

    // Random traffic with random consumer backpressure.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (m_gnt >= 0) p_v[m_gnt] = 0;
      for (int k = 0; k < 2; k++)
        if (!p_v[k] && $urandom_range(0, 2) == 0) new_req(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
